seg7_show_driver: RTL and testbench

- Multiplexed 8-digit seven-segment display driver for the board-level top, next to the MIPS CPU.
- Displays a 32-bit value either as 8 hex digits (CPU LED data) or as 8 decimal digits (cycle, branch and jump counters).
- Scans one digit at a time using active-low anode and segment outputs (common-anode board).

---
 rtl/seg7_show_driver.sv | 69 ++++++
 tb/tb_seg7_show_driver.sv | 137 +++++++++++++
 2 files changed

// File: rtl/seg7_show_driver.sv
// seg7_show_driver: 8-digit multiplexed common-anode 7-seg driver showing data as hex or as decimal.
// Decimal digits come from a free-running sequential double-dabble converter (32 clk per result).
module seg7_show_driver #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        mod,
  input  logic [31:0] data,
  output logic [7:0]  SEG,
  output logic [7:0]  AN
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [127:0] PAT = {8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
                                  8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    seg_q, seg_d, an_q, an_d;
  logic [31:0]   sh_q, sh_d, acc_q, acc_d, bcd_q, bcd_d, adj, acc_n, sh_n;
  logic [4:0]    iter_q, iter_d;
  logic          busy_q, busy_d, wrap, load, last;
  logic [3:0]    nib;
  assign SEG = seg_q;
  assign AN  = an_q;
  always_comb begin
    wrap  = cnt_q == CW'(SCAN_DIV - 1);
    cnt_d = wrap ? '0 : cnt_q + CW'(1);
    idx_d = idx_q + {2'b00, wrap};
    nib   = mod ? data[{idx_q, 2'b00} +: 4] : bcd_q[{idx_q, 2'b00} +: 4];
    seg_d = PAT[{nib, 3'b000} +: 8];
    an_d  = ~(8'b1 << idx_q);
  end
  // BCD digits beyond the 8th fall off the top of acc, which yields data mod 10^8
  always_comb begin
    for (int k = 0; k < 8; k++)
      adj[4*k +: 4] = (acc_q[4*k +: 4] > 4'd4) ? acc_q[4*k +: 4] + 4'd3 : acc_q[4*k +: 4];
    {acc_n, sh_n} = {adj, sh_q} << 1;
    last   = busy_q && (iter_q == 5'd31);
    load   = !busy_q || last;
    busy_d = 1'b1;
    sh_d   = load ? data : sh_n;
    acc_d  = load ? '0 : acc_n;
    iter_d = load ? '0 : iter_q + 5'd1;
    bcd_d  = last ? acc_n : bcd_q;
  end
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      seg_q  <= 8'hFF;
      an_q   <= 8'hFF;
      sh_q   <= '0;
      acc_q  <= '0;
      bcd_q  <= '0;
      iter_q <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
      sh_q   <= sh_d;
      acc_q  <= acc_d;
      bcd_q  <= bcd_d;
      iter_q <= iter_d;
      busy_q <= busy_d;
    end
  end
endmodule

// File: tb/tb_seg7_show_driver.sv
// tb_seg7_show_driver: randomized checks of scan, hex and decimal display against an arithmetic model.
module tb_seg7_show_driver;
  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        mod = 1'b1;
  logic [31:0] data = '0;
  logic [7:0]  SEG, AN;
  int checks = 0;
  int errors = 0;
  int k;
  logic [7:0] pats [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg7_show_driver #(.SCAN_DIV(2)) dut (.clk(clk), .clr(clr), .mod(mod), .data(data), .SEG(SEG), .AN(AN));

  always #5 clk = ~clk;

  // edges since reset release; digit shown after edge k was selected by the index held before it
  always @(posedge clk or negedge clr)
    if (!clr) k <= 0;
    else k <= k + 1;

  function automatic int exp_idx(int kk);
    return ((kk - 1) / 2) % 8;
  endfunction

  function automatic logic [7:0] exp_an(int kk);
    logic [7:0] one = 8'd1;
    return ~(one << exp_idx(kk));
  endfunction

  function automatic logic [7:0] exp_seg(logic m, logic [31:0] d, int i);
    longint unsigned v = longint'(d) % 100000000;
    int digit;
    for (int j = 0; j < i; j++) v = v / 10;
    digit = m ? int'((d >> (4 * i)) & 32'hF) : int'(v % 10);
    return pats[digit];
  endfunction

  task automatic test_reset();
    clr = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (SEG !== 8'hFF) begin errors++; $display("FAIL reset_seg got %h want FF", SEG); end
    checks++;
    if (AN !== 8'hFF) begin errors++; $display("FAIL reset_an got %h want FF", AN); end
    clr = 1'b1;
    for (int c = 0; c < 34; c++) begin
      @(negedge clk);
      checks++;
      if (AN !== exp_an(k)) begin errors++; $display("FAIL scan_an k=%0d got %h want %h", k, AN, exp_an(k)); end
    end
  endtask

  task automatic show_check(string name, int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      checks++;
      if (AN !== exp_an(k) || SEG !== exp_seg(mod, data, exp_idx(k))) begin
        errors++;
        $display("FAIL %s data=%h mod=%0d got AN=%h SEG=%h want AN=%h SEG=%h",
                 name, data, mod, AN, SEG, exp_an(k), exp_seg(mod, data, exp_idx(k)));
      end
    end
  endtask

  task automatic test_hex();
    logic [31:0] vals [4];
    vals[0] = 32'h89ABCDEF;
    for (int v = 1; v < 4; v++) vals[v] = $urandom;
    mod = 1'b1;
    foreach (vals[v]) begin
      data = vals[v];
      @(negedge clk);
      show_check("hex", 16);
    end
  endtask

  task automatic test_dec();
    logic [31:0] vals [7];
    vals[0] = 32'd12345678;
    vals[1] = 32'd123456789;
    vals[2] = 32'd0;
    vals[3] = 32'hFFFFFFFF;
    for (int v = 4; v < 7; v++) vals[v] = $urandom;
    mod = 1'b0;
    foreach (vals[v]) begin
      data = vals[v];
      repeat (70) @(negedge clk);
      show_check("dec", 16);
    end
  endtask

  task automatic test_mode_switch();
    mod  = 1'b1;
    data = 32'd16;
    repeat (70) @(negedge clk);
    show_check("switch_hex", 8);
    mod = 1'b0;
    show_check("switch_dec", 16);
    mod = 1'b1;
    show_check("switch_back", 8);
  endtask

  task automatic test_reset_mid();
    mod  = 1'b0;
    data = $urandom;
    repeat (70) @(negedge clk);
    data = $urandom;
    repeat (11) @(negedge clk);
    @(posedge clk);
    #2 clr = 1'b0;
    #1;
    checks++;
    if (SEG !== 8'hFF || AN !== 8'hFF) begin
      errors++;
      $display("FAIL mid_reset got SEG=%h AN=%h want FF FF", SEG, AN);
    end
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    checks++;
    if (AN !== 8'hFE) begin errors++; $display("FAIL mid_reset_an got %h want FE", AN); end
    repeat (34) @(negedge clk);
    show_check("recover_dec", 16);
  endtask

  initial begin
    test_reset();
    test_hex();
    test_dec();
    test_mode_switch();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
